// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the dual-master Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT0  = 2'd1,
        GNT1  = 2'd2,
        ABORT = 2'd3
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int unsigned WD_W = 16;

endpackage

// File: rtl/wb_dual_master_arbiter.sv
// Round-robin arbiter sharing one Wishbone master port between two masters,
// with whole-cycle locking and a stall watchdog that aborts hung accesses.
module wb_dual_master_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 24,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [DATA_WIDTH-1:0] m0_dat_i,
    output logic [DATA_WIDTH-1:0] m0_dat_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [DATA_WIDTH-1:0] m1_dat_i,
    output logic [DATA_WIDTH-1:0] m1_dat_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [DATA_WIDTH-1:0] s_dat_o,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    input  logic                  s_ack_i,
    output logic [1:0]            grant_o,
    output logic [15:0]           timeout_count_o
);

    // Watchdog terminal count: the last stalled cycle still allowed to complete.
    localparam logic [WD_W-1:0] WD_TC = WD_W'(TIMEOUT - 1);

    state_t          r_state;
    state_t          w_next;
    logic            r_last;
    logic            r_abort_owner;
    logic [WD_W-1:0] r_wd;
    logic [WD_W-1:0] w_wd_next;
    logic [15:0]     r_tocnt;
    logic            r_m0_err;
    logic            r_m1_err;
    logic            w_owner;
    logic            w_granted;
    logic            w_own_cyc;
    logic            w_own_stb;
    logic            w_oth_cyc;
    logic            w_release;
    logic            w_abort;

    // Owner of the bus, including while an aborted cycle drains.
    assign w_owner   = (r_state == GNT1) || ((r_state == ABORT) && (r_abort_owner == M1));
    assign w_granted = (r_state == GNT0) || (r_state == GNT1);
    assign w_own_cyc = w_owner ? m1_cyc_i : m0_cyc_i;
    assign w_own_stb = w_owner ? m1_stb_i : m0_stb_i;
    assign w_oth_cyc = w_owner ? m0_cyc_i : m1_cyc_i;

    assign m0_err_o        = r_m0_err;
    assign m1_err_o        = r_m1_err;
    assign timeout_count_o = r_tocnt;

    // Next-state, watchdog and bus-mux logic.
    always_comb begin
        w_next    = r_state;
        w_release = 1'b0;
        w_abort   = 1'b0;
        w_wd_next = '0;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        m0_ack_o  = 1'b0;
        m1_ack_o  = 1'b0;
        m0_dat_o  = '0;
        m1_dat_o  = '0;
        grant_o   = 2'b00;

        case (r_state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    w_next = (r_last == M1) ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    w_next = GNT0;
                end else if (m1_cyc_i) begin
                    w_next = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (!w_own_cyc) begin
                    w_release = 1'b1;
                end else if (w_own_stb && !s_ack_i && (r_wd == WD_TC)) begin
                    w_abort = 1'b1;
                    w_next  = ABORT;
                end
            end
            ABORT: begin
                if (!w_own_cyc) begin
                    w_release = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase

        if (w_release) begin
            w_next = w_oth_cyc ? (w_owner ? GNT0 : GNT1) : IDLE;
        end

        if (w_granted && (w_next == r_state) && w_own_stb && !s_ack_i) begin
            w_wd_next = r_wd + WD_W'(1);
        end

        if (w_granted) begin
            s_cyc_o = w_own_cyc;
            s_stb_o = w_own_stb;
            s_we_o  = w_owner ? m1_we_i  : m0_we_i;
            s_adr_o = w_owner ? m1_adr_i : m0_adr_i;
            s_dat_o = w_owner ? m1_dat_i : m0_dat_i;
            if (w_owner) begin
                m1_ack_o = s_ack_i;
                m1_dat_o = s_dat_i;
            end else begin
                m0_ack_o = s_ack_i;
                m0_dat_o = s_dat_i;
            end
        end

        if (r_state != IDLE) begin
            grant_o = w_owner ? 2'b10 : 2'b01;
        end
    end

    // State, arbitration history, watchdog and abort bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_last        <= M1;
            r_abort_owner <= M0;
            r_wd          <= '0;
            r_tocnt       <= '0;
            r_m0_err      <= 1'b0;
            r_m1_err      <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_wd     <= w_wd_next;
            r_m0_err <= w_abort && (w_owner == M0);
            r_m1_err <= w_abort && (w_owner == M1);
            if (w_release) begin
                r_last <= w_owner;
            end
            if (w_abort) begin
                r_abort_owner <= w_owner;
                if (r_tocnt != 16'hFFFF) begin
                    r_tocnt <= r_tocnt + 16'd1;
                end
            end
        end
    end

endmodule
